// File: rtl/config_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : config_chain_loader
// Purpose  : Loads a serial configuration chain (daisy-chained config tiles).
//            Host words arrive over a valid/ready handshake, are serialised
//            MSB-first onto the chain head with one shift-enable pulse per
//            bit, and after exactly CHAIN_LEN bits a commit (set) pulse of
//            SET_HOLD cycles latches the chain into the live registers.
// Ports    : clk, rst_n (async, active-low)
//            i_start      - load request, honoured only when idle
//            i_abort      - synchronous abort, back to idle, no commit
//            i_word_data  - host word, MSB shifted first
//            i_word_valid - host word valid
//            o_word_ready - loader accepts a word this cycle
//            o_cfg_cen    - chain shift enable (one bit per high cycle)
//            o_cfg_shift  - serial data into the chain head
//            o_cfg_set    - commit pulse to the chain
//            o_busy       - loader not idle
//            o_done       - one-cycle pulse once the load is committed
//            o_crc_out    - CRC-16-CCITT of shifted bits (0 when disabled)
// Options  : CONFIG_LOADER_CRC_EN - enables the running CRC on o_crc_out.
// Revision : 1.0 - initial release
// ============================================================================
module config_chain_loader #(
  parameter int CHAIN_LEN = 1152,
  parameter int WORD_W    = 32,
  parameter int SET_HOLD  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [WORD_W-1:0] i_word_data,
  input  logic              i_word_valid,
  output logic              o_word_ready,
  output logic              o_cfg_cen,
  output logic              o_cfg_shift,
  output logic              o_cfg_set,
  output logic              o_busy,
  output logic              o_done,
  output logic [15:0]       o_crc_out
);

  localparam int BCW = $clog2(CHAIN_LEN + 1);
  localparam int WBW = $clog2(WORD_W + 1);
  localparam int HCW = $clog2(SET_HOLD + 1);
  localparam logic [BCW-1:0] C_CHAIN_LEN = BCW'(CHAIN_LEN);
  localparam logic [WBW-1:0] C_WORD_W    = WBW'(WORD_W);
  localparam logic [HCW-1:0] C_SET_HOLD  = HCW'(SET_HOLD);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_SET   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [WORD_W-1:0] r_sh, w_sh_nxt;          // remaining bits of current word
  logic [BCW-1:0]    r_bit_cnt, w_bit_cnt_nxt;   // bits emitted, incl. the one on o_cfg_shift
  logic [WBW-1:0]    r_word_bit, w_word_bit_nxt; // bits of current word emitted
  logic [HCW-1:0]    r_hold, w_hold_nxt;      // set cycles already driven
  logic              r_cfg_cen, w_cen_nxt;
  logic              r_cfg_shift, w_shift_nxt;
  logic              r_cfg_set, w_set_nxt;
  logic              r_done, w_done_nxt;
  logic              w_word_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sh        <= '0;
      r_bit_cnt   <= '0;
      r_word_bit  <= '0;
      r_hold      <= '0;
      r_cfg_cen   <= 1'b0;
      r_cfg_shift <= 1'b0;
      r_cfg_set   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sh        <= w_sh_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_word_bit  <= w_word_bit_nxt;
      r_hold      <= w_hold_nxt;
      r_cfg_cen   <= w_cen_nxt;
      r_cfg_shift <= w_shift_nxt;
      r_cfg_set   <= w_set_nxt;
      r_done      <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_sh_nxt       = r_sh;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_word_bit_nxt = r_word_bit;
    w_hold_nxt     = r_hold;
    w_cen_nxt      = 1'b0;
    w_shift_nxt    = 1'b0;
    w_set_nxt      = 1'b0;
    w_done_nxt     = 1'b0;
    w_word_ready   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt    = S_LOAD;
          w_sh_nxt       = '0;
          w_bit_cnt_nxt  = '0;
          w_word_bit_nxt = '0;
        end
      end

      S_LOAD: begin
        w_word_ready = 1'b1;
        if (i_word_valid) begin
          w_state_nxt    = S_SHIFT;
          w_cen_nxt      = 1'b1;
          w_shift_nxt    = i_word_data[WORD_W-1];
          w_sh_nxt       = i_word_data << 1;
          w_word_bit_nxt = WBW'(1);
          w_bit_cnt_nxt  = r_bit_cnt + 1'b1;
        end
      end

      S_SHIFT: begin
        if (r_bit_cnt == C_CHAIN_LEN) begin
          // Chain full: any unshifted bits of this word are dropped.
          w_state_nxt = S_SET;
          w_set_nxt   = 1'b1;
          w_hold_nxt  = HCW'(1);
        end else if (r_word_bit == C_WORD_W) begin
          // Last bit of the word is on the chain now; taking the next word
          // in this same cycle keeps the bit stream gapless.
          w_word_ready = 1'b1;
          if (i_word_valid) begin
            w_cen_nxt      = 1'b1;
            w_shift_nxt    = i_word_data[WORD_W-1];
            w_sh_nxt       = i_word_data << 1;
            w_word_bit_nxt = WBW'(1);
            w_bit_cnt_nxt  = r_bit_cnt + 1'b1;
          end else begin
            w_state_nxt = S_LOAD;
          end
        end else begin
          w_cen_nxt      = 1'b1;
          w_shift_nxt    = r_sh[WORD_W-1];
          w_sh_nxt       = r_sh << 1;
          w_word_bit_nxt = r_word_bit + 1'b1;
          w_bit_cnt_nxt  = r_bit_cnt + 1'b1;
        end
      end

      S_SET: begin
        if (r_hold == C_SET_HOLD) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_set_nxt  = 1'b1;
          w_hold_nxt = r_hold + 1'b1;
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Abort overrides everything, including a same-cycle start.
    if (i_abort) begin
      w_state_nxt = S_IDLE;
      w_cen_nxt   = 1'b0;
      w_shift_nxt = 1'b0;
      w_set_nxt   = 1'b0;
      w_done_nxt  = 1'b0;
    end
  end

  assign o_word_ready = w_word_ready;
  assign o_cfg_cen    = r_cfg_cen;
  assign o_cfg_shift  = r_cfg_shift;
  assign o_cfg_set    = r_cfg_set;
  assign o_done       = r_done;
  assign o_busy       = (r_state != S_IDLE);

`ifdef CONFIG_LOADER_CRC_EN
  logic [15:0] r_crc;
  logic        w_crc_fb;
  logic        w_start_acc;

  assign w_start_acc = (r_state == S_IDLE) & i_start & ~i_abort;
  assign w_crc_fb    = r_crc[15] ^ r_cfg_shift;

  // The CRC follows the bits as they leave on the chain, so it tracks the
  // registered shift outputs rather than the incoming word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= 16'h0000;
    end else if (w_start_acc) begin
      r_crc <= 16'hFFFF;
    end else if (r_cfg_cen) begin
      r_crc <= {r_crc[14:0], 1'b0} ^ (w_crc_fb ? 16'h1021 : 16'h0000);
    end
  end

  assign o_crc_out = r_crc;
`else
  assign o_crc_out = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_config_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_config_chain_loader
// Purpose  : Directed self-checking bench for config_chain_loader.
//            Instance 0: CHAIN_LEN=40, instance 1: CHAIN_LEN=36,
//            instance 2: CHAIN_LEN=8; all WORD_W=8, SET_HOLD=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_config_chain_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] word_data = 8'h00;
  logic       word_valid = 1'b0;
  logic       start [3];
  logic       ready [3];
  logic       cen   [3];
  logic       shift [3];
  logic       set   [3];
  logic       busy  [3];
  logic       done  [3];
  logic [15:0] crc  [3];

  always #5 clk = ~clk;

  config_chain_loader #(.CHAIN_LEN(40), .WORD_W(8), .SET_HOLD(2)) u_dut40 (
    .clk(clk), .rst_n(rst_n), .i_start(start[0]), .i_abort(abort),
    .i_word_data(word_data), .i_word_valid(word_valid), .o_word_ready(ready[0]),
    .o_cfg_cen(cen[0]), .o_cfg_shift(shift[0]), .o_cfg_set(set[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_crc_out(crc[0]));

  config_chain_loader #(.CHAIN_LEN(36), .WORD_W(8), .SET_HOLD(2)) u_dut36 (
    .clk(clk), .rst_n(rst_n), .i_start(start[1]), .i_abort(abort),
    .i_word_data(word_data), .i_word_valid(word_valid), .o_word_ready(ready[1]),
    .o_cfg_cen(cen[1]), .o_cfg_shift(shift[1]), .o_cfg_set(set[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_crc_out(crc[1]));

  config_chain_loader #(.CHAIN_LEN(8), .WORD_W(8), .SET_HOLD(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .i_start(start[2]), .i_abort(abort),
    .i_word_data(word_data), .i_word_valid(word_valid), .o_word_ready(ready[2]),
    .o_cfg_cen(cen[2]), .o_cfg_shift(shift[2]), .o_cfg_set(set[2]),
    .o_busy(busy[2]), .o_done(done[2]), .o_crc_out(crc[2]));

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  words [8];
  logic [63:0] stream;
  int n_cen, n_gap, n_set, n_done, n_acc, n_loadwait, n_ovl;
  int last_cen, first_set, last_set, done_cyc;
  logic busy_after, timed_out;

  // Runs one load on instance sel, recording what appears on the chain.
  // mode 1: abort, 2: extra start, 3: async reset - once evt_bit bits are out.
  task automatic run_load(input int sel, input int nwords, input int stall_after,
                          input int stall_len, input int mode, input int evt_bit);
    int idx, stall_cnt, pending;
    bit fired, valid_now;
    n_cen = 0; n_gap = 0; n_set = 0; n_done = 0; n_acc = 0; n_loadwait = 0; n_ovl = 0;
    stream = '0; last_cen = -1; first_set = -1; last_set = -1; done_cyc = -1;
    busy_after = 1'b1; timed_out = 1'b0;
    idx = 0; stall_cnt = 0; pending = 0; fired = 1'b0;
    @(negedge clk); start[sel] = 1'b1;
    @(negedge clk); start[sel] = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (cen[sel]) begin
        n_cen++;
        stream = {stream[62:0], shift[sel]};
        n_gap += pending;
        pending = 0;
        last_cen = cyc;
      end else if (n_cen > 0 && busy[sel] && !set[sel]) begin
        pending++;
      end
      if (set[sel]) begin
        n_set++;
        if (first_set < 0) first_set = cyc;
        last_set = cyc;
        if (cen[sel]) n_ovl++;
      end
      if (ready[sel] && !cen[sel]) n_loadwait++;
      if (done[sel]) begin
        n_done++;
        done_cyc = cyc;
        word_valid = 1'b0;
        @(negedge clk);
        busy_after = busy[sel];
        return;
      end
      start[sel] = 1'b0;
      if (!fired && mode != 0 && n_cen == evt_bit) begin
        fired = 1'b1;
        case (mode)
          1: begin
            word_valid = 1'b0; abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            return;
          end
          2: start[sel] = 1'b1;
          3: begin
            word_valid = 1'b0;
            #2 rst_n = 1'b0;
            #1;
            return;
          end
          default: ;
        endcase
      end
      valid_now = (idx < nwords);
      if (valid_now && idx == stall_after && ready[sel] && stall_cnt < stall_len) begin
        valid_now = 1'b0;
        stall_cnt++;
      end
      word_valid = valid_now;
      word_data  = valid_now ? words[idx] : 8'h00;
      if (valid_now && ready[sel]) begin
        idx++;
        n_acc++;
      end
      @(negedge clk);
    end
    timed_out = 1'b1;
    word_valid = 1'b0;
    start[sel] = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({busy[i], cen[i], shift[i], set[i], done[i], ready[i], crc[i]} !== 22'd0) begin
        n_errors++;
        $display("FAIL reset_outputs[%0d]: got %0h required 0", i,
                 {busy[i], cen[i], shift[i], set[i], done[i], ready[i], crc[i]});
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_abort_start_same_cycle();
    start[0] = 1'b1; abort = 1'b1;
    @(negedge clk);
    start[0] = 1'b0; abort = 1'b0;
    n_checks++;
    if (busy[0] !== 1'b0) begin
      n_errors++; $display("FAIL abort_beats_start: busy got %0b required 0", busy[0]);
    end
  endtask

  task automatic test_basic_load();
    words = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h00, 8'h00, 8'h00};
    run_load(0, 5, -1, 0, 0, -1);
    n_checks++; if (timed_out !== 1'b0) begin n_errors++; $display("FAIL basic_timeout: got %0b required 0", timed_out); end
    n_checks++; if (n_acc != 5) begin n_errors++; $display("FAIL basic_words: got %0d required 5", n_acc); end
    n_checks++; if (n_cen != 40) begin n_errors++; $display("FAIL basic_cen_count: got %0d required 40", n_cen); end
    n_checks++; if (stream[39:0] !== 40'hA53CFF0081) begin n_errors++; $display("FAIL basic_stream: got %h required a53cff0081", stream[39:0]); end
    n_checks++; if (n_gap != 0) begin n_errors++; $display("FAIL basic_gaps: got %0d required 0", n_gap); end
    n_checks++; if (n_loadwait != 1) begin n_errors++; $display("FAIL basic_load_cycles: got %0d required 1", n_loadwait); end
    n_checks++; if (n_set != 2) begin n_errors++; $display("FAIL basic_set_len: got %0d required 2", n_set); end
    n_checks++; if (first_set != last_cen + 1) begin n_errors++; $display("FAIL basic_set_start: got %0d required %0d", first_set, last_cen + 1); end
    n_checks++; if (n_ovl != 0) begin n_errors++; $display("FAIL basic_set_cen_overlap: got %0d required 0", n_ovl); end
    n_checks++; if (done_cyc != last_set + 1) begin n_errors++; $display("FAIL basic_done_pos: got %0d required %0d", done_cyc, last_set + 1); end
    n_checks++; if (busy_after !== 1'b0) begin n_errors++; $display("FAIL basic_busy_after: got %0b required 0", busy_after); end
  endtask

  task automatic test_partial_word();
    words = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'h00, 8'h00};
    run_load(1, 6, -1, 0, 0, -1);
    n_checks++; if (n_acc != 5) begin n_errors++; $display("FAIL partial_words: got %0d required 5", n_acc); end
    n_checks++; if (n_cen != 36) begin n_errors++; $display("FAIL partial_cen_count: got %0d required 36", n_cen); end
    n_checks++; if (stream[35:0] !== 36'h123456789) begin n_errors++; $display("FAIL partial_stream: got %h required 123456789", stream[35:0]); end
    n_checks++; if (n_done != 1 || n_set != 2) begin n_errors++; $display("FAIL partial_commit: done %0d set %0d required 1 and 2", n_done, n_set); end
  endtask

  task automatic test_host_stall();
    words = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h00, 8'h00, 8'h00};
    run_load(0, 5, 2, 7, 0, -1);
    n_checks++; if (n_gap != 7) begin n_errors++; $display("FAIL stall_gap: got %0d required 7", n_gap); end
    n_checks++; if (n_loadwait != 8) begin n_errors++; $display("FAIL stall_load_cycles: got %0d required 8", n_loadwait); end
    n_checks++; if (n_cen != 40) begin n_errors++; $display("FAIL stall_cen_count: got %0d required 40", n_cen); end
    n_checks++; if (stream[39:0] !== 40'hA53CFF0081) begin n_errors++; $display("FAIL stall_stream: got %h required a53cff0081", stream[39:0]); end
  endtask

  task automatic test_abort();
    int hits;
    words = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h00, 8'h00, 8'h00};
    run_load(0, 5, -1, 0, 1, 17);
    n_checks++;
    if ({busy[0], cen[0], set[0], ready[0], done[0]} !== 5'b0) begin
      n_errors++; $display("FAIL abort_next_cycle: got %b required 00000", {busy[0], cen[0], set[0], ready[0], done[0]});
    end
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      if (set[0] || done[0] || cen[0]) hits++;
      @(negedge clk);
    end
    n_checks++; if (hits != 0) begin n_errors++; $display("FAIL abort_no_commit: got %0d required 0", hits); end
    run_load(0, 5, -1, 0, 0, -1);
    n_checks++; if (n_cen != 40 || stream[39:0] !== 40'hA53CFF0081) begin
      n_errors++; $display("FAIL abort_reload: cen %0d stream %h required 40 a53cff0081", n_cen, stream[39:0]);
    end
  endtask

  task automatic test_ignored_start();
    run_load(0, 5, -1, 0, 2, 10);
    n_checks++; if (n_cen != 40 || n_acc != 5) begin n_errors++; $display("FAIL ignored_start_count: cen %0d words %0d required 40 5", n_cen, n_acc); end
    n_checks++; if (stream[39:0] !== 40'hA53CFF0081) begin n_errors++; $display("FAIL ignored_start_stream: got %h required a53cff0081", stream[39:0]); end
  endtask

  task automatic test_reset_mid_shift();
    int hits;
    run_load(0, 5, -1, 0, 3, 20);
    n_checks++;
    if ({busy[0], cen[0], shift[0], set[0], done[0], ready[0], crc[0]} !== 22'd0) begin
      n_errors++; $display("FAIL reset_async: got %h required 0", {busy[0], cen[0], shift[0], set[0], done[0], ready[0], crc[0]});
    end
    hits = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (set[0] || busy[0]) hits++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (set[0] || busy[0] || done[0]) hits++;
    end
    n_checks++; if (hits != 0) begin n_errors++; $display("FAIL reset_no_set: got %0d required 0", hits); end
  endtask

  task automatic test_crc();
    logic [15:0] exp_crc;
`ifdef CONFIG_LOADER_CRC_EN
    exp_crc = 16'hC782;
`else
    exp_crc = 16'h0000;
`endif
    words = '{8'h31, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_load(2, 1, -1, 0, 0, -1);
    n_checks++; if (n_cen != 8 || stream[7:0] !== 8'h31) begin n_errors++; $display("FAIL crc_stream: cen %0d data %h required 8 31", n_cen, stream[7:0]); end
    n_checks++; if (crc[2] !== exp_crc) begin n_errors++; $display("FAIL crc_value: got %h required %h", crc[2], exp_crc); end
    repeat (3) @(negedge clk);
    n_checks++; if (crc[2] !== exp_crc) begin n_errors++; $display("FAIL crc_hold: got %h required %h", crc[2], exp_crc); end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    test_reset();
    test_abort_start_same_cycle();
    test_basic_load();
    test_partial_word();
    test_host_stall();
    test_abort();
    test_ignored_start();
    test_reset_mid_shift();
    test_crc();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
